// File: rtl/sprite_blitter_if.sv
// Bus bundle between the CPU execute stage, main memory, the VDP command port
// and the sprite blitter. The blitter uses the slave view; the environment
// (CPU, memory, VDP) uses the master view.
interface sprite_blitter_if;
   // CPU draw request
   logic        start;
   logic [7:0]  vx;
   logic [7:0]  vy;
   logic [3:0]  n;
   logic [11:0] iAddr;
   // CPU status / result
   logic        busy;
   logic        done;
   logic        collision;
   // main-memory read port
   logic [11:0] memAddr;
   logic        memRead;
   logic [7:0]  memData;
   // VDP command port
   logic [2:0]  cmd;
   logic [7:0]  cmdData;
   logic        spriteHit;

   modport slave (
      input  start, vx, vy, n, iAddr, memData, spriteHit,
      output busy, done, collision, memAddr, memRead, cmd, cmdData
   );

   modport master (
      output start, vx, vy, n, iAddr, memData, spriteHit,
      input  busy, done, collision, memAddr, memRead, cmd, cmdData
   );
endinterface

// File: rtl/sprite_blitter.sv
// CHIP-8 DXYN sprite blitter: fetches N sprite rows from memory, issues
// SETX / SETY / XOR_BYTE triplets to the VDP and ORs the VDP hit flag into
// a single collision result. All outputs are registered and track the state
// register, so each output is valid in the cycle its state is occupied.
module sprite_blitter #(
   parameter int SCREEN_W    = 64,
   parameter int SCREEN_H    = 32,
   parameter int HIT_LATENCY = 2
) (
   input logic             clk,
   input logic             reset,
   sprite_blitter_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_CHECK, S_FETCH, S_WAIT, S_SETX, S_SETY, S_XOR, S_HIT, S_DONE
   } state_t;

   localparam logic [2:0]      CMD_NONE = 3'd0;
   localparam logic [2:0]      CMD_SETX = 3'd1;
   localparam logic [2:0]      CMD_SETY = 3'd2;
   localparam logic [2:0]      CMD_XOR  = 3'd3;
   localparam int              HCW      = (HIT_LATENCY > 1) ? $clog2(HIT_LATENCY) : 1;
   localparam logic [HCW-1:0]  HIT_LAST = HCW'(HIT_LATENCY - 1);
   localparam logic [7:0]      X_MASK   = 8'(SCREEN_W - 1);
   localparam logic [7:0]      Y_MASK   = 8'(SCREEN_H - 1);
   localparam logic [8:0]      H_LIMIT  = 9'(SCREEN_H);

   state_t           state_q, state_d;
   logic [7:0]       x0_q, x0_d;
   logic [7:0]       y0_q, y0_d;
   logic [3:0]       n_q, n_d;
   logic [11:0]      base_q, base_d;
   logic [3:0]       row_q, row_d;
   logic [7:0]       byte_q, byte_d;
   logic [HCW-1:0]   hit_cnt_q, hit_cnt_d;
   logic             coll_q, coll_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             mem_read_q, mem_read_d;
   logic [11:0]      mem_addr_q, mem_addr_d;
   logic [2:0]       cmd_q, cmd_d;
   logic [7:0]       cmd_data_q, cmd_data_d;
   logic [8:0]       cur_y_s;

   // 9-bit screen row of the current sprite row, so bottom-edge clipping cannot wrap
   assign cur_y_s = {1'b0, y0_q} + {5'd0, row_q};

   // Next-state, latch updates and next registered output values
   always_comb begin
      state_d    = state_q;
      x0_d       = x0_q;
      y0_d       = y0_q;
      n_d        = n_q;
      base_d     = base_q;
      row_d      = row_q;
      byte_d     = byte_q;
      hit_cnt_d  = hit_cnt_q;
      coll_d     = coll_q;
      done_d     = 1'b0;
      mem_read_d = 1'b0;
      mem_addr_d = mem_addr_q;
      cmd_d      = CMD_NONE;
      cmd_data_d = 8'd0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               x0_d    = bus.vx & X_MASK;
               y0_d    = bus.vy & Y_MASK;
               n_d     = bus.n;
               base_d  = bus.iAddr;
               row_d   = 4'd0;
               coll_d  = 1'b0;
               state_d = S_CHECK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CHECK: begin
            if ((row_q == n_q) || (cur_y_s >= H_LIMIT)) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               mem_read_d = 1'b1;
               mem_addr_d = base_q + {8'd0, row_q};
               state_d    = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            byte_d     = bus.memData;
            cmd_d      = CMD_SETX;
            cmd_data_d = x0_q;
            state_d    = S_SETX;
         end
         S_SETX: begin
            cmd_d      = CMD_SETY;
            cmd_data_d = cur_y_s[7:0];
            state_d    = S_SETY;
         end
         S_SETY: begin
            cmd_d      = CMD_XOR;
            cmd_data_d = byte_q;
            hit_cnt_d  = {HCW{1'b0}};
            state_d    = S_XOR;
         end
         S_XOR: begin
            state_d = S_HIT;
         end
         S_HIT: begin
            coll_d = coll_q | bus.spriteHit;
            if (hit_cnt_q == HIT_LAST) begin
               hit_cnt_d = {HCW{1'b0}};
               row_d     = row_q + 4'd1;
               state_d   = S_CHECK;
            end else begin
               hit_cnt_d = hit_cnt_q + HCW'(1);
               state_d   = S_HIT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State, latches and registered outputs; reset aborts any draw in progress
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         x0_q       <= 8'd0;
         y0_q       <= 8'd0;
         n_q        <= 4'd0;
         base_q     <= 12'd0;
         row_q      <= 4'd0;
         byte_q     <= 8'd0;
         hit_cnt_q  <= {HCW{1'b0}};
         coll_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mem_read_q <= 1'b0;
         mem_addr_q <= 12'd0;
         cmd_q      <= CMD_NONE;
         cmd_data_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         n_q        <= n_d;
         base_q     <= base_d;
         row_q      <= row_d;
         byte_q     <= byte_d;
         hit_cnt_q  <= hit_cnt_d;
         coll_q     <= coll_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         mem_read_q <= mem_read_d;
         mem_addr_q <= mem_addr_d;
         cmd_q      <= cmd_d;
         cmd_data_q <= cmd_data_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.collision = coll_q;
   assign bus.memRead   = mem_read_q;
   assign bus.memAddr   = mem_addr_q;
   assign bus.cmd       = cmd_q;
   assign bus.cmdData   = cmd_data_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: expected memory reads, VDP commands and
// done/collision events are queued when a draw is launched and checked in
// order as the blitter produces them; draw timing is checked separately.
module tb_sprite_blitter;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   sprite_blitter_if sb ();

   sprite_blitter #(
      .SCREEN_W    (64),
      .SCREEN_H    (32),
      .HIT_LATENCY (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sb)
   );

   typedef struct packed {
      logic [2:0]  kind;   // 1 SETX, 2 SETY, 3 XOR, 4 read, 5 done
      logic [11:0] val;
   } ev_t;

   int          total = 0;
   int          bad   = 0;
   ev_t         exp_q[$];
   logic [7:0]  mem [4096];

   function automatic ev_t mk(input logic [2:0] k, input logic [11:0] v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic observe(input logic [2:0] k, input logic [11:0] v);
      ev_t e;
      total++;
      assert (exp_q.size() > 0) else begin
         bad++;
         $error("FAIL sb_unexpected observed=%0d/%h expected=none", k, v);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         assert ({k, v} === {e.kind, e.val}) else begin
            bad++;
            $error("FAIL sb_event observed=%0d/%h expected=%0d/%h", k, v, e.kind, e.val);
         end
      end
   endtask

   // memory model: data for the address presented is valid in the following cycle
   always @(negedge clk) sb.memData = mem[sb.memAddr];

   // scoreboard monitor, sampling mid-cycle
   always @(negedge clk) begin
      if (reset) begin
         if (sb.memRead)        observe(3'd4, sb.memAddr);
         if (sb.cmd != 3'd0)    observe(sb.cmd, {4'd0, sb.cmdData});
         if (sb.done)           observe(3'd5, {11'd0, sb.collision});
      end
   end

   // reference model of one draw: wrap X/Y, clip at the bottom edge
   task automatic push_draw(input logic [7:0] vx, input logic [7:0] vy, input logic [3:0] n,
                            input logic [11:0] ia, input logic c, output int rows);
      int x0;
      int y0;
      logic [11:0] a;
      x0 = vx % 64;
      y0 = vy % 32;
      rows = 0;
      for (int r = 0; r < n && (y0 + r) < 32; r++) begin
         a = ia + 12'(r);
         exp_q.push_back(mk(3'd4, a));
         exp_q.push_back(mk(3'd1, 12'(x0)));
         exp_q.push_back(mk(3'd2, 12'(y0 + r)));
         exp_q.push_back(mk(3'd3, {4'd0, mem[a]}));
         rows++;
      end
      exp_q.push_back(mk(3'd5, {11'd0, c}));
   endtask

   // launch one draw; optional spriteHit pulse, re-start pulse and reset, by cycle number
   task automatic run(input string tag, input logic [7:0] vx, input logic [7:0] vy,
                      input logic [3:0] n, input logic [11:0] ia, input logic c,
                      input int hit_cyc, input int restart_cyc, input int rst_cyc);
      int rows;
      int cyc;
      bit aborted;
      aborted = 1'b0;
      push_draw(vx, vy, n, ia, c, rows);
      sb.vx = vx; sb.vy = vy; sb.n = n; sb.iAddr = ia;
      sb.start = 1'b1;
      @(posedge clk); #1;
      sb.start = 1'b0;
      cyc = 1;
      chk({tag, "_busy_rise"}, {31'd0, sb.busy}, 32'd1);
      chk({tag, "_coll_clear"}, {31'd0, sb.collision}, 32'd0);
      while (!sb.done && cyc < 400 && !aborted) begin
         sb.spriteHit = (cyc == hit_cyc);
         sb.start     = (cyc == restart_cyc);
         if (cyc == rst_cyc) begin
            reset   = 1'b0;
            aborted = 1'b1;
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      sb.spriteHit = 1'b0;
      sb.start     = 1'b0;
      if (aborted) begin
         #1;
         chk({tag, "_rst_outs"},
             {17'd0, sb.busy, sb.done, sb.collision, sb.memRead, sb.cmd, sb.cmdData}, 32'd0);
         chk({tag, "_rst_addr"}, {20'd0, sb.memAddr}, 32'd0);
         chk({tag, "_rst_left"}, 32'(exp_q.size()), 32'd3);
         exp_q.delete();
         repeat (3) @(posedge clk);
         #1;
         reset = 1'b1;
         @(posedge clk); #1;
         chk({tag, "_rst_idle"}, {30'd0, sb.busy, sb.done}, 32'd0);
      end else begin
         chk({tag, "_done_cycle"}, 32'(cyc), 32'(2 + rows * 8));
         chk({tag, "_coll"}, {31'd0, sb.collision}, {31'd0, c});
         chk({tag, "_busy_at_done"}, {31'd0, sb.busy}, 32'd1);
         @(posedge clk); #1;
         chk({tag, "_done_pulse"}, {30'd0, sb.done, sb.busy}, 32'd0);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[12'h300] = 8'hF0; mem[12'h301] = 8'h0F;
      mem[12'h310] = 8'h81; mem[12'h311] = 8'h00; mem[12'h312] = 8'h3C;
      mem[12'h320] = 8'h99;
      mem[12'h330] = 8'hA5; mem[12'h331] = 8'h5A; mem[12'h332] = 8'hFF;
      mem[12'hFFF] = 8'hAA; mem[12'h000] = 8'h55;
      sb.start = 1'b0; sb.vx = 8'd0; sb.vy = 8'd0; sb.n = 4'd0;
      sb.iAddr = 12'd0; sb.spriteHit = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", {17'd0, sb.busy, sb.done, sb.collision, sb.memRead, sb.cmd, sb.cmdData}, 32'd0);
      chk("reset_addr", {20'd0, sb.memAddr}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      run("single", 8'd5, 8'd3, 4'd1, 12'h300, 1'b0, 0, 0, 0);
      run("collide", 8'd12, 8'd7, 4'd3, 12'h310, 1'b1, 15, 0, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("coll_hold", {31'd0, sb.collision}, 32'd1);
      run("hit_outside", 8'd12, 8'd7, 4'd3, 12'h310, 1'b0, 12, 0, 0);
      run("wrap_xy", 8'd70, 8'd33, 4'd1, 12'h320, 1'b0, 0, 0, 0);
      run("clip_bottom", 8'd0, 8'd30, 4'd5, 12'h330, 1'b0, 0, 0, 0);
      run("addr_wrap", 8'd63, 8'd0, 4'd2, 12'hFFF, 1'b0, 0, 0, 0);
      run("n_zero", 8'd9, 8'd9, 4'd0, 12'h300, 1'b0, 0, 0, 0);
      run("restart_busy", 8'd10, 8'd4, 4'd2, 12'h300, 1'b0, 0, 5, 0);
      run("reset_mid", 8'd1, 8'd2, 4'd3, 12'h310, 1'b0, 0, 0, 21);
      run("after_reset", 8'd5, 8'd3, 4'd1, 12'h300, 1'b0, 0, 0, 0);

      repeat (4) @(posedge clk);
      #1;
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Executes the CHIP-8 DXYN draw for the CPU core.
- Fetches N sprite bytes from main memory starting at I and issues SETX / SETY / XOR_BYTE command triplets to the VDP command port.
- Gathers the VDP spriteHit flag into a single collision result, which the CPU writes to VF.
- Sits between the CPU execute stage and the VDP.

Parameters:
- SCREEN_W, 64, horizontal resolution in pixels; start X is reduced modulo this value (power of 2).
- SCREEN_H, 32, vertical resolution in rows; start Y is reduced modulo this value (power of 2).
- HIT_LATENCY, 2, cycles after XOR_BYTE during which spriteHit is sampled (minimum 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle draw request; sampled only in IDLE.
- vx  in  8  sprite X coordinate (VX).
- vy  in  8  sprite Y coordinate (VY).
- n  in  4  sprite height in rows.
- iAddr  in  12  sprite base address (I).
- busy  out  1  high while a draw is in progress.
- done  out  1  one-cycle pulse when the draw completes.
- collision  out  1  VF result; valid when done is high and held until the next accepted start.
- memAddr  out  12  main-memory read address.
- memRead  out  1  read strobe; memData is valid on the cycle after memRead.
- memData  in  8  sprite byte.
- cmd  out  3  VDP command: NONE=000, SETX=001, SETY=010, XOR_BYTE=011.
- cmdData  out  8  VDP command operand.
- spriteHit  in  1  VDP collision flag.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE.
  - busy, done, collision, memRead = 0; memAddr = 0.
  - cmd = NONE, cmdData = 0.
  - Row counter and latches cleared.
  - Reset mid-draw aborts immediately. No done pulse. No further commands issued.
- On start in IDLE:
  - Latch x0 = vx mod SCREEN_W, y0 = vy mod SCREEN_H, n, iAddr.
  - Clear collision. Row r = 0.
- States and transitions:
  - IDLE -> CHECK on start. start in any other state is ignored.
  - CHECK: if r == n or y0 + r >= SCREEN_H (compare at 9 bits), go to DONE. Otherwise go to FETCH.
    - Rows below the bottom edge are clipped. No vertical wrap.
    - n = 0 goes straight to DONE.
  - FETCH:
    - memAddr = iAddr + r (12-bit, wraps at 0xFFF -> 0x000), memRead = 1.
    - -> WAIT.
  - WAIT: latch memData into the row byte. -> SETX.
  - SETX: cmd = SETX, cmdData = x0. -> SETY.
  - SETY: cmd = SETY, cmdData = y0 + r. -> XOR.
  - XOR: cmd = XOR_BYTE, cmdData = row byte. -> HIT.
    - Zero bytes are still issued.
    - Horizontal clipping is the VDP's job.
  - HIT: stay HIT_LATENCY cycles with collision |= spriteHit each cycle. Then r += 1, -> CHECK.
  - DONE: done = 1 for one cycle. -> IDLE.
- Output timing:
  - cmd is NONE and memRead is 0 in every state not listed above.
  - busy = 1 in every state except IDLE.
  - busy is registered: it rises the cycle after start and falls the cycle after done.
- Timing, with start accepted at cycle 0:
  - Each drawn row costs 1 (CHECK) + 5 + HIT_LATENCY cycles.
  - DONE follows the final CHECK.
  - Unclipped draw: done at cycle 2 + n*(6+HIT_LATENCY). With HIT_LATENCY=2, n=1 gives cycle 10.
  - n=0: done at cycle 2, collision 0.
- collision holds its value after done until the next accepted start clears it.
- spriteHit is ignored outside the HIT state.

Test Plan:
- Single row: vx=5, vy=3, n=1, iAddr=0x300, mem[0x300]=0xF0, spriteHit=0.
  -> memAddr=0x300 at cycle 2.
  -> cmds SETX/5, SETY/3, XOR/0xF0 on consecutive cycles.
  -> done at cycle 10, collision=0.
- Collision: n=3, spriteHit pulsed one cycle during row 1's HIT window.
  -> three command triplets issued.
  -> collision=1 at done and held until the next start.
  -> spriteHit asserted outside any HIT window leaves collision=0.
- Wrap and clip:
  - vx=70, vy=33 -> SETX/6, SETY/1.
  - vy=30, n=5 -> only rows Y=30 and Y=31 issued; memAddr only I and I+1; done after 2 rows.
  - iAddr=0xFFF, n=2 -> reads 0xFFF then 0x000.
- n=0 -> no memRead, no cmd other than NONE, done at cycle 2, collision=0.
- start pulsed while busy -> ignored; the original draw completes unchanged with exactly one done pulse.
- reset asserted (low) during row 2's SETY -> outputs go to reset values immediately, no done pulse.
  -> after release, a new start draws correctly.
